// File: rtl/vm_irq_pkg.sv
// Shared types and constants for the vectored interrupt arbiter.
// Default vectors match the peripheral-processor map.
package vm_irq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    PASS  = 2'd2
  } vm_state_e;

  localparam int VEC_W = 16;

  localparam logic [VEC_W-1:0] VEC_TIMER = 16'o304;
  localparam logic [VEC_W-1:0] VEC_KBD   = 16'o300;
  localparam logic [VEC_W-1:0] VEC_SER   = 16'o310;
  localparam logic [VEC_W-1:0] VEC_SND   = 16'o314;

endpackage

// File: rtl/vm_prio_enc.sv
// Fixed-priority encoder, bit 0 wins.
// Gives one-hot grant, binary index and an any flag.
module vm_prio_enc #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan from the top so the lowest set bit is the last to win.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IW'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vm_virq_arbiter.sv
// Vectored interrupt arbiter with arm latches.
// Unclaimed acknowledge cycles go down the daisy chain.
module vm_virq_arbiter
  import vm_irq_pkg::*;
#(
  parameter int NREQ = 4,
  parameter logic [16*NREQ-1:0] VECTORS =
    {VEC_SND, VEC_SER, VEC_KBD, VEC_TIMER}
) (
  input  logic              pin_vm_clk_p,
  input  logic              pin_vm_rst_n_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   mask_i,
  input  logic [NREQ-1:0]   rearm_i,
  output logic [NREQ-1:0]   served_o,
  output logic              pin_vm_virq_o,
  input  logic              pin_wbi_stb_i,
  output logic              pin_wbi_ack_o,
  output logic [VEC_W-1:0]  pin_wbi_dat_o,
  output logic              pin_wbi_stb_o,
  input  logic              pin_wbi_ack_i,
  input  logic [VEC_W-1:0]  pin_wbi_dat_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  vm_state_e        state_q;
  vm_state_e        state_d;
  logic [NREQ-1:0]  armed_q;
  logic             stb_old_q;
  logic             ack_q;
  logic             ack_d;
  logic [VEC_W-1:0] dat_q;
  logic [VEC_W-1:0] dat_d;
  logic             stb_q;
  logic             stb_d;
  logic [NREQ-1:0]  served_q;
  logic [NREQ-1:0]  served_d;
  logic [NREQ-1:0]  clr_d;

  logic [NREQ-1:0]  pending;
  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    idx;
  logic             any;
  logic             rise;
  logic [VEC_W-1:0] vec_sel;

  assign pending       = req_i & mask_i & armed_q;
  assign rise          = pin_wbi_stb_i & ~stb_old_q;
  assign pin_vm_virq_o = |pending;

  assign pin_wbi_ack_o = ack_q;
  assign pin_wbi_dat_o = dat_q;
  assign pin_wbi_stb_o = stb_q;
  assign served_o      = served_q;

  vm_prio_enc #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_enc (
    .req   (pending),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  // Vector lookup for the winning source.
  always_comb begin
    vec_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (idx == IW'(i))
        vec_sel = VECTORS[16*i +: 16];
    end
  end

  // State register.
  always_ff @(posedge pin_vm_clk_p) begin
    if (!pin_vm_rst_n_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rise)
          state_d = any ? GRANT : PASS;
      end
      GRANT: begin
        if (!pin_wbi_stb_i)
          state_d = IDLE;
      end
      PASS: begin
        if (!pin_wbi_stb_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered bus outputs.
  always_comb begin
    ack_d    = 1'b0;
    dat_d    = '0;
    stb_d    = 1'b0;
    served_d = '0;
    clr_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (rise && any) begin
          ack_d    = 1'b1;
          dat_d    = vec_sel;
          served_d = grant;
          clr_d    = grant;
        end else if (rise) begin
          stb_d = 1'b1;
        end
      end
      GRANT: begin
        if (pin_wbi_stb_i) begin
          ack_d = ack_q;
          dat_d = dat_q;
        end
      end
      PASS: begin
        if (pin_wbi_stb_i) begin
          stb_d = 1'b1;
          ack_d = pin_wbi_ack_i;
          dat_d = pin_wbi_ack_i ? pin_wbi_dat_i : '0;
        end
      end
      default: ;
    endcase
  end

  // Output, edge-detect and arm-latch registers; grant clear beats rearm.
  always_ff @(posedge pin_vm_clk_p) begin
    if (!pin_vm_rst_n_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      stb_q     <= 1'b0;
      served_q  <= '0;
      stb_old_q <= 1'b1;
      armed_q   <= '1;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      stb_q     <= stb_d;
      served_q  <= served_d;
      stb_old_q <= pin_wbi_stb_i;
      armed_q   <= (armed_q | rearm_i) & ~clr_d;
    end
  end

endmodule

// File: tb/tb_vm_virq_arbiter.sv
// Directed bench for vm_virq_arbiter.
// Hand-computed vectors, immediate assertions.
module tb_vm_virq_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  mask;
  logic [3:0]  rearm;
  logic [3:0]  served;
  logic        virq;
  logic        stb_i;
  logic        ack_o;
  logic [15:0] dat_o;
  logic        stb_o;
  logic        ack_i;
  logic [15:0] dat_i;

  int total;
  int passed;

  vm_virq_arbiter u_dut (
    .pin_vm_clk_p   (clk),
    .pin_vm_rst_n_i (rst_n),
    .req_i          (req),
    .mask_i         (mask),
    .rearm_i        (rearm),
    .served_o       (served),
    .pin_vm_virq_o  (virq),
    .pin_wbi_stb_i  (stb_i),
    .pin_wbi_ack_o  (ack_o),
    .pin_wbi_dat_o  (dat_o),
    .pin_wbi_stb_o  (stb_o),
    .pin_wbi_ack_i  (ack_i),
    .pin_wbi_dat_i  (dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    req    = '0;
    mask   = 4'hF;
    rearm  = '0;
    stb_i  = 1'b0;
    ack_i  = 1'b0;
    dat_i  = '0;
    tick();
    tick();
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_dat", 32'(dat_o), 32'd0);
    chk("rst_stb", 32'(stb_o), 32'd0);
    chk("rst_served", 32'(served), 32'd0);
    chk("rst_armed", 32'(u_dut.armed_q), 32'hF);
    rst_n = 1'b1;
    tick();

    // single request
    req = 4'b0001;
    #1;
    chk("t1_virq_hi", 32'(virq), 32'd1);
    stb_i = 1'b1;
    tick();
    chk("t1_ack", 32'(ack_o), 32'd1);
    chk("t1_dat", 32'(dat_o), 32'o304);
    chk("t1_served", 32'(served), 32'b0001);
    chk("t1_virq_lo", 32'(virq), 32'd0);
    tick();
    chk("t1_served_1cyc", 32'(served), 32'd0);
    chk("t1_ack_hold", 32'(ack_o), 32'd1);
    chk("t1_dat_hold", 32'(dat_o), 32'o304);
    stb_i = 1'b0;
    tick();
    chk("t1_ack_drop", 32'(ack_o), 32'd0);
    chk("t1_dat_drop", 32'(dat_o), 32'd0);

    // priority
    rearm = 4'b0001;
    tick();
    rearm = '0;
    req   = 4'b0110;
    stb_i = 1'b1;
    tick();
    chk("t2_dat1", 32'(dat_o), 32'o300);
    chk("t2_served1", 32'(served), 32'b0010);
    chk("t2_armed1", 32'(u_dut.armed_q), 32'b1101);
    chk("t2_virq_still", 32'(virq), 32'd1);
    stb_i = 1'b0;
    tick();
    chk("t2_ack_drop1", 32'(ack_o), 32'd0);
    stb_i = 1'b1;
    tick();
    chk("t2_dat2", 32'(dat_o), 32'o310);
    chk("t2_served2", 32'(served), 32'b0100);
    stb_i = 1'b0;
    tick();
    chk("t2_virq_lo", 32'(virq), 32'd0);
    rearm = 4'b0010;
    tick();
    rearm = '0;
    #1;
    chk("t2_virq_rearm", 32'(virq), 32'd1);

    // pass-through
    req = '0;
    tick();
    stb_i = 1'b1;
    tick();
    chk("t3_stb_o", 32'(stb_o), 32'd1);
    chk("t3_ack_lo", 32'(ack_o), 32'd0);
    ack_i = 1'b1;
    dat_i = 16'o320;
    tick();
    chk("t3_ack_fwd", 32'(ack_o), 32'd1);
    chk("t3_dat_fwd", 32'(dat_o), 32'o320);
    stb_i = 1'b0;
    ack_i = 1'b0;
    tick();
    chk("t3_stb_drop", 32'(stb_o), 32'd0);
    chk("t3_ack_drop", 32'(ack_o), 32'd0);
    chk("t3_dat_drop", 32'(dat_o), 32'd0);

    // masked source
    mask = 4'b1110;
    req  = 4'b0001;
    #1;
    chk("t4_virq_masked", 32'(virq), 32'd0);
    stb_i = 1'b1;
    tick();
    chk("t4_stb_o", 32'(stb_o), 32'd1);
    chk("t4_served", 32'(served), 32'd0);
    chk("t4_armed_kept", 32'(u_dut.armed_q), 32'b1011);
    stb_i = 1'b0;
    tick();
    chk("t4_stb_drop", 32'(stb_o), 32'd0);

    // grant and rearm of src3 together
    mask  = 4'hF;
    req   = 4'b1000;
    rearm = 4'b1000;
    stb_i = 1'b1;
    tick();
    rearm = '0;
    chk("t4_dat3", 32'(dat_o), 32'o314);
    chk("t4_served3", 32'(served), 32'b1000);
    chk("t4_armed3", 32'(u_dut.armed_q[3]), 32'd0);
    stb_i = 1'b0;
    tick();

    // reset during GRANT, strobe held high
    req   = 4'b0010;
    stb_i = 1'b1;
    tick();
    chk("t5_ack", 32'(ack_o), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_ack", 32'(ack_o), 32'd0);
    chk("t5_rst_dat", 32'(dat_o), 32'd0);
    chk("t5_rst_stb", 32'(stb_o), 32'd0);
    chk("t5_rst_armed", 32'(u_dut.armed_q), 32'hF);
    rst_n = 1'b1;
    tick();
    tick();
    chk("t5_no_ack", 32'(ack_o), 32'd0);
    chk("t5_no_stb", 32'(stb_o), 32'd0);
    stb_i = 1'b0;
    tick();
    stb_i = 1'b1;
    tick();
    chk("t5_ack_again", 32'(ack_o), 32'd1);
    chk("t5_dat_again", 32'(dat_o), 32'o300);
    stb_i = 1'b0;
    tick();
    chk("t5_ack_end", 32'(ack_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
